fetch_pc_gen: RTL and testbench

- Front-end fetch-address generator and fetch-packet former, sitting directly upstream of branch presolve.
- Owns the fetch PC and issues one 8-byte-aligned I-cache request at a time.
- Turns each I-cache response into a fetch pack (two 32-bit instruction slots) for presolve and the fetch queue.
- Takes redirects from the backend (highest priority), from presolve, and from the BPU.

---
 rtl/fetch_pc_gen_pkg.sv | 38 +++
 rtl/fetch_pack_slot.sv | 38 +++
 rtl/fetch_pc_gen.sv | 183 ++++++++++++++++++
 tb/tb_fetch_pc_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_gen_pkg
//  Description : Shared front-end types for the fetch PC generator: fetch-pack
//                and redirect structs, FSM state encoding, fetch geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pc_gen_pkg;

    localparam int PC_W        = 64;
    localparam int INST_W      = 32;
    localparam int FETCH_BYTES = 8;
    localparam int FETCH_OFF_W = $clog2(FETCH_BYTES);

    // One registered fetch pack as presented to presolve / fetch queue.
    typedef struct packed {
        logic [1:0]        valids;
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst1;
        logic [INST_W-1:0] inst0;
        logic              pred_valid;
        logic              pred_taken;
    } fetch_pack_t;

    // Resolved redirect request (backend or presolve, already arbitrated).
    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
    } redirect_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage : fetch_pc_gen_pkg
`default_nettype wire

// File: rtl/fetch_pack_slot.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pack_slot
//  Description : Single registered fetch-pack slot. Holds while the consumer
//                stalls, clears on consumption, flushes on backend redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pack_slot
    import fetch_pc_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  fetch_pack_t load_pack,
    input  logic        flush,
    input  logic        consume,
    output fetch_pack_t pack
);

    fetch_pack_t r_pack;

    // Flush beats a new load; a load replaces a pack draining this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pack <= '0;
        end else if (flush) begin
            r_pack <= '0;
        end else if (load) begin
            r_pack <= load_pack;
        end else if (consume) begin
            r_pack <= '0;
        end
    end

    assign pack = r_pack;

endmodule : fetch_pack_slot
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_gen
//  Description : Fetch PC owner and fetch-pack former. Issues one aligned
//                I-cache request at a time, applies backend / presolve / BPU
//                redirects and turns responses into two-slot fetch packs.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          XLEN     = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_i_stall,
    input  logic            io_i_redirect_valid,
    input  logic [XLEN-1:0] io_i_redirect_pc,
    input  logic            io_i_branch_presolve_pack_valid,
    input  logic [XLEN-1:0] io_i_branch_presolve_pack_pc,
    input  logic            io_i_bpu_taken,
    input  logic [XLEN-1:0] io_i_bpu_target,
    output logic            io_o_icache_req_valid,
    output logic [XLEN-1:0] io_o_icache_req_addr,
    input  logic            io_i_icache_req_ready,
    input  logic            io_i_icache_resp_valid,
    input  logic [63:0]     io_i_icache_resp_data,
    output logic            io_o_fetch_pack_valids_0,
    output logic            io_o_fetch_pack_valids_1,
    output logic [XLEN-1:0] io_o_fetch_pack_pc,
    output logic [31:0]     io_o_fetch_pack_insts_0,
    output logic [31:0]     io_o_fetch_pack_insts_1,
    output logic            io_o_fetch_pack_branch_predict_pack_valid,
    output logic            io_o_fetch_pack_branch_predict_pack_taken
);

    state_t          r_state;
    state_t          w_state_n;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_n;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] w_req_pc_n;
    logic            r_kill;
    logic            w_kill_n;
    logic            r_pred_valid;
    logic            w_pred_valid_n;
    logic            r_pred_taken;
    logic            w_pred_taken_n;

    logic            w_req_valid;
    logic            w_hs;
    logic            w_load;
    logic            w_pack_valid;
    logic            w_consumed;
    logic [XLEN-1:0] w_aligned_pc;
    logic [XLEN-1:0] w_seq_pc;
    redirect_t       w_redir;
    fetch_pack_t     w_load_pack;
    fetch_pack_t     w_pack;

    assign w_pack_valid = w_pack.valids[0] | w_pack.valids[1];
    assign w_consumed   = w_pack_valid & ~io_i_stall;
    assign w_aligned_pc = {r_pc[XLEN-1:FETCH_OFF_W], {FETCH_OFF_W{1'b0}}};
    assign w_seq_pc     = w_aligned_pc + XLEN'(FETCH_BYTES);

    // Backend redirect wins; presolve only counts while its pack is on the output.
    always_comb begin
        w_redir.valid = io_i_redirect_valid
                      | (io_i_branch_presolve_pack_valid & w_pack_valid);
        w_redir.pc    = io_i_redirect_valid ? io_i_redirect_pc
                                            : io_i_branch_presolve_pack_pc;
    end

    // Next-state, fetch PC and kill control.
    always_comb begin
        w_state_n      = r_state;
        w_pc_n         = r_pc;
        w_req_pc_n     = r_req_pc;
        w_kill_n       = r_kill;
        w_pred_valid_n = r_pred_valid;
        w_pred_taken_n = r_pred_taken;
        w_req_valid    = 1'b0;
        w_hs           = 1'b0;
        w_load         = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_n = REQ;
                if (w_redir.valid) begin
                    w_pc_n = w_redir.pc;
                end
            end
            REQ: begin
                // Only request when the slot is free by the time the response lands.
                w_req_valid = ~w_pack_valid | w_consumed;
                w_hs        = w_req_valid & io_i_icache_req_ready;
                if (w_hs) begin
                    w_state_n      = WAIT;
                    w_req_pc_n     = r_pc;
                    w_pred_valid_n = 1'b1;
                    w_pred_taken_n = io_i_bpu_taken;
                    w_kill_n       = w_redir.valid;
                    if (w_redir.valid) begin
                        w_pc_n = w_redir.pc;
                    end else if (io_i_bpu_taken) begin
                        w_pc_n = io_i_bpu_target;
                    end else begin
                        w_pc_n = w_seq_pc;
                    end
                end else if (w_redir.valid) begin
                    w_pc_n = w_redir.pc;
                end
            end
            WAIT: begin
                if (w_redir.valid) begin
                    w_kill_n = 1'b1;
                    w_pc_n   = w_redir.pc;
                end
                // A response retires the outstanding request whether kept or dropped.
                if (io_i_icache_resp_valid) begin
                    w_state_n = REQ;
                    w_kill_n  = 1'b0;
                    w_load    = ~r_kill & ~w_redir.valid;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_pc         <= XLEN'(RESET_PC);
            r_req_pc     <= '0;
            r_kill       <= 1'b0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_pc         <= w_pc_n;
            r_req_pc     <= w_req_pc_n;
            r_kill       <= w_kill_n;
            r_pred_valid <= w_pred_valid_n;
            r_pred_taken <= w_pred_taken_n;
        end
    end

    // Pack formation: a PC in the upper word only yields the upper instruction.
    always_comb begin
        w_load_pack.valids     = {~r_req_pc[2], 1'b1};
        w_load_pack.pc         = r_req_pc;
        w_load_pack.inst0      = r_req_pc[2] ? io_i_icache_resp_data[63:32]
                                             : io_i_icache_resp_data[31:0];
        w_load_pack.inst1      = io_i_icache_resp_data[63:32];
        w_load_pack.pred_valid = r_pred_valid;
        w_load_pack.pred_taken = r_pred_taken;
    end

    fetch_pack_slot u_slot (
        .clk       (clock),
        .rst_n     (reset),
        .load      (w_load),
        .load_pack (w_load_pack),
        .flush     (io_i_redirect_valid),
        .consume   (w_consumed),
        .pack      (w_pack)
    );

    assign io_o_icache_req_valid                     = w_req_valid;
    assign io_o_icache_req_addr                      = w_aligned_pc;
    assign io_o_fetch_pack_valids_0                  = w_pack.valids[0];
    assign io_o_fetch_pack_valids_1                  = w_pack.valids[1];
    assign io_o_fetch_pack_pc                        = w_pack.pc;
    assign io_o_fetch_pack_insts_0                   = w_pack.inst0;
    assign io_o_fetch_pack_insts_1                   = w_pack.inst1;
    assign io_o_fetch_pack_branch_predict_pack_valid = w_pack.pred_valid;
    assign io_o_fetch_pack_branch_predict_pack_taken = w_pack.pred_taken;

endmodule : fetch_pc_gen
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_pc_gen
//  Description : Directed self-checking bench for fetch_pc_gen with a
//                one-cycle-latency I-cache responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_gen;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        pres_valid;
    logic [63:0] pres_pc;
    logic        bpu_taken;
    logic [63:0] bpu_target;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        v0;
    logic        v1;
    logic [63:0] pk_pc;
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic        pred_valid;
    logic        pred_taken;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    fetch_pc_gen #(
        .RESET_PC (64'h8000_0000),
        .XLEN     (64)
    ) dut (
        .clock                                     (clock),
        .reset                                     (reset),
        .io_i_stall                                (stall),
        .io_i_redirect_valid                       (redir_valid),
        .io_i_redirect_pc                          (redir_pc),
        .io_i_branch_presolve_pack_valid           (pres_valid),
        .io_i_branch_presolve_pack_pc              (pres_pc),
        .io_i_bpu_taken                            (bpu_taken),
        .io_i_bpu_target                           (bpu_target),
        .io_o_icache_req_valid                     (req_valid),
        .io_o_icache_req_addr                      (req_addr),
        .io_i_icache_req_ready                     (req_ready),
        .io_i_icache_resp_valid                    (resp_valid),
        .io_i_icache_resp_data                     (resp_data),
        .io_o_fetch_pack_valids_0                  (v0),
        .io_o_fetch_pack_valids_1                  (v1),
        .io_o_fetch_pack_pc                        (pk_pc),
        .io_o_fetch_pack_insts_0                   (inst0),
        .io_o_fetch_pack_insts_1                   (inst1),
        .io_o_fetch_pack_branch_predict_pack_valid (pred_valid),
        .io_o_fetch_pack_branch_predict_pack_taken (pred_taken)
    );

    // Memory image: reset vector holds two known instructions, everything
    // else returns {addr+4, addr} so expected words are easy to derive.
    function automatic logic [63:0] mem(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        if (a == 64'h8000_0000) return 64'h0000_0013_0000_0093;
        return {lo + 32'd4, lo};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 units after the edge.
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    // I-cache: capture a handshake mid-cycle, answer in the following cycle.
    initial begin
        logic        hs;
        logic [63:0] a;
        resp_valid = 1'b0;
        resp_data  = '0;
        forever begin
            @(negedge clock);
            hs = reset & req_valid & req_ready;
            a  = req_addr;
            @(posedge clock);
            #1;
            resp_valid = hs;
            resp_data  = hs ? mem(a) : 64'h0;
        end
    end

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        pres_valid  = 1'b0;
        pres_pc     = '0;
        bpu_taken   = 1'b0;
        bpu_target  = '0;
        req_ready   = 1'b1;
        cyc();
        cyc();

        // Reset values
        check("rst_req_valid", {63'd0, req_valid}, 64'd0);
        check("rst_valids", {62'd0, v0, v1}, 64'd0);
        check("rst_pack_pc", pk_pc, 64'd0);
        check("rst_req_addr", req_addr, 64'h8000_0000);

        // First fetch after reset release
        reset = 1'b1;
        cyc();
        check("first_req_valid", {63'd0, req_valid}, 64'd1);
        check("first_req_addr", req_addr, 64'h8000_0000);
        cyc();
        check("wait_no_req", {63'd0, req_valid}, 64'd0);
        cyc();
        check("p0_pc", pk_pc, 64'h8000_0000);
        check("p0_inst0", {32'd0, inst0}, 64'h0000_0093);
        check("p0_inst1", {32'd0, inst1}, 64'h0000_0013);
        check("p0_valids", {62'd0, v0, v1}, 64'b11);
        check("p0_pred_valid", {63'd0, pred_valid}, 64'd1);
        check("p0_pred_taken", {63'd0, pred_taken}, 64'd0);
        check("p0_next_addr", req_addr, 64'h8000_0008);

        // Backend redirect in WAIT drops the same-cycle response
        cyc();
        check("br_consumed", {63'd0, v0}, 64'd0);
        redir_valid = 1'b1;
        redir_pc    = 64'h8000_1004;
        cyc();
        redir_valid = 1'b0;
        check("br_drop", {62'd0, v0, v1}, 64'd0);
        check("br_addr", req_addr, 64'h8000_1000);
        check("br_req_valid", {63'd0, req_valid}, 64'd1);
        cyc();
        check("br_still_empty", {62'd0, v0, v1}, 64'd0);
        cyc();
        check("br_pack_pc", pk_pc, 64'h8000_1004);
        check("br_valids", {62'd0, v0, v1}, 64'b10);
        check("br_inst0", {32'd0, inst0}, 64'h8000_1004);
        check("br_inst1", {32'd0, inst1}, 64'h8000_1004);

        // BPU taken at handshake of the reset vector
        do_reset();
        bpu_taken  = 1'b1;
        bpu_target = 64'h8000_0100;
        cyc();
        check("bpu_req_addr", req_addr, 64'h8000_0000);
        cyc();
        bpu_taken = 1'b0;
        cyc();
        check("bpu_pack_pc", pk_pc, 64'h8000_0000);
        check("bpu_pred_valid", {63'd0, pred_valid}, 64'd1);
        check("bpu_pred_taken", {63'd0, pred_taken}, 64'd1);
        check("bpu_next_addr", req_addr, 64'h8000_0100);

        // Presolve redirect coinciding with the next request's handshake
        do_reset();
        cyc();
        cyc();
        cyc();
        pres_valid = 1'b1;
        pres_pc    = 64'h8000_0008;
        #1;
        check("ps_req_valid", {63'd0, req_valid}, 64'd1);
        check("ps_pack_kept", {63'd0, v0}, 64'd1);
        cyc();
        pres_valid = 1'b0;
        check("ps_wait", {63'd0, req_valid}, 64'd0);
        cyc();
        check("ps_killed", {62'd0, v0, v1}, 64'd0);
        check("ps_readdr", req_addr, 64'h8000_0008);
        check("ps_rereq", {63'd0, req_valid}, 64'd1);
        cyc();
        cyc();
        check("ps_pack_pc", pk_pc, 64'h8000_0008);
        check("ps_inst0", {32'd0, inst0}, 64'h8000_0008);
        check("ps_inst1", {32'd0, inst1}, 64'h8000_000C);

        // Stall holds the pack and blocks requests; presolve reroutes only
        stall = 1'b1;
        #1;
        check("st_req_blocked", {63'd0, req_valid}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("st_pc", pk_pc, 64'h8000_0008);
            check("st_valids", {62'd0, v0, v1}, 64'b11);
            check("st_req_valid", {63'd0, req_valid}, 64'd0);
            if (i == 2) begin
                check("st_ps_addr", req_addr, 64'h8000_0040);
                pres_valid = 1'b0;
            end
            if (i == 1) begin
                pres_valid = 1'b1;
                pres_pc    = 64'h8000_0040;
            end
        end
        stall = 1'b0;
        #1;
        check("st_release_req", {63'd0, req_valid}, 64'd1);
        cyc();
        check("st_drained", {62'd0, v0, v1}, 64'd0);
        check("st_in_wait", {63'd0, req_valid}, 64'd0);

        // Backend and presolve together while the pack is held
        do_reset();
        cyc();
        cyc();
        cyc();
        stall       = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 64'h8000_2000;
        pres_valid  = 1'b1;
        pres_pc     = 64'h8000_0040;
        cyc();
        stall       = 1'b0;
        redir_valid = 1'b0;
        pres_valid  = 1'b0;
        check("both_flush", {62'd0, v0, v1}, 64'd0);
        check("both_pc_cleared", pk_pc, 64'd0);
        check("both_addr", req_addr, 64'h8000_2000);
        cyc();
        check("both_wait", {63'd0, req_valid}, 64'd0);
        check("both_seq_addr", req_addr, 64'h8000_2008);

        // Asynchronous reset mid-WAIT
        reset = 1'b0;
        #1;
        check("ar_req_valid", {63'd0, req_valid}, 64'd0);
        check("ar_addr", req_addr, 64'h8000_0000);
        check("ar_valids", {62'd0, v0, v1}, 64'd0);
        check("ar_pred", {62'd0, pred_valid, pred_taken}, 64'd0);
        cyc();
        reset = 1'b1;
        cyc();
        check("ar_restart_addr", req_addr, 64'h8000_0000);
        check("ar_restart_req", {63'd0, req_valid}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_pc_gen
`default_nettype wire
